spi_burst_sequencer: RTL and testbench
======================================

Name: spi_burst_sequencer

Overview:
Sequences the SPI transmit datapath from the synchronized button events. next_count_pe steps an internal value counter. start_send_pe launches a burst of BURST_LEN words (count, count+1, ...) into the SPI core over a valid/ready handshake. Each word must complete (spi_done) before the next is issued. Sits between button_handler/sync_fd outputs and the SPI master.

Parameters:
DATA_W, 8, width of counter and SPI word
BURST_LEN, 4, words per burst (>=1)
GAP_CYC, 2, idle cycles between words of a burst (0 allowed)
TIMEOUT, 1024, max cycles waiting for spi_done before abort (>=2)

Ports:
clk_100  in  1  system clock
a_rst_n  in  1  asynchronous active-low reset
s_rst  in  1  synchronous clear, active-high
next_count_pe  in  1  single-cycle pulse, increment counter
start_send_pe  in  1  single-cycle pulse, start burst
tx_ready  in  1  SPI core accepts word
spi_done  in  1  single-cycle pulse, current word shifted out
tx_valid  out  1  word on tx_data is valid
tx_data  out  DATA_W  word to transmit
count  out  DATA_W  current counter value
busy  out  1  high whenever state != IDLE
err_timeout  out  1  sticky, spi_done not seen within TIMEOUT
burst_cnt  out  16  completed bursts, wraps at 0xFFFF->0

Behaviour:
- Reset (a_rst_n low, async) and s_rst (sync, priority over all else): state IDLE; count=0, tx_valid=0, tx_data=0, busy=0, err_timeout=0, burst_cnt=0, word index=0.
- Counter: next_count_pe increments count mod 2^DATA_W (0xFF->0x00 for DATA_W=8) only in IDLE. Ignored in other states.
- States: IDLE, SEND, WAIT_DONE, GAP.
- IDLE:
  - start_send_pe latches base=count, idx=0, goes to SEND.
  - tx_valid rises the cycle after the pulse (latency 1).
  - next_count_pe and start_send_pe in the same cycle: base = pre-increment count, count still increments.
- SEND:
  - tx_valid=1, tx_data=base+idx mod 2^DATA_W.
  - tx_data is held stable while tx_valid=1 and tx_ready=0; no timeout applies in SEND.
  - On tx_valid&&tx_ready: WAIT_DONE, tx_valid=0 next cycle, timeout counter cleared.
- WAIT_DONE:
  - Counts cycles.
  - spi_done arriving on the same cycle as entry is not possible, because the handshake precedes it by >=1 cycle. spi_done is accepted from the first WAIT_DONE cycle onward.
  - On spi_done with idx==BURST_LEN-1: IDLE, burst_cnt+1.
  - On spi_done with idx<BURST_LEN-1: idx+1. Goes to GAP, or to SEND directly if GAP_CYC=0.
  - If TIMEOUT cycles elapse without spi_done: err_timeout=1, IDLE, burst_cnt unchanged, burst abandoned.
- GAP: waits exactly GAP_CYC cycles with tx_valid=0, then SEND.
- spi_done outside WAIT_DONE: ignored. start_send_pe outside IDLE: ignored, with no queuing.
- err_timeout is cleared only by reset/s_rst. New bursts are still accepted while it is set.
- busy is registered from state: 1 from the cycle tx_valid first rises through the cycle before return to IDLE.
- tx_data retains its last value when tx_valid=0.

Test Plan:
- Reset, 3x next_count_pe, start_send_pe, tx_ready=1, spi_done 5 cycles after each handshake -> words 0x03,0x04,0x05,0x06. tx_valid low exactly GAP_CYC=2 cycles between WAIT_DONE exit and next SEND. burst_cnt=1, busy=0 afterwards.
- count=0xFE, start burst -> tx_data 0xFE,0xFF,0x00,0x01. 255 next_count pulses from 0x01 -> count=0x00.
- tx_ready held 0 for 20 cycles during SEND -> tx_valid stays 1, tx_data stable. Handshake then proceeds, no err_timeout.
- No spi_done after first handshake -> err_timeout=1 after 1024 cycles, IDLE, burst_cnt=0. Next burst completes normally and err_timeout stays 1.
- next_count_pe and start_send_pe in the same cycle with count=0x10 -> first word 0x10, count=0x11. start_send_pe and next_count_pe mid-burst -> ignored.
- a_rst_n low mid-WAIT_DONE -> all outputs 0 immediately. Repeat with s_rst -> cleared next edge; spurious spi_done afterwards ignored.

Source files
------------

// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer
//   Drives the SPI transmit datapath from synchronized button events.
//   next_count_pe steps a value counter while idle. start_send_pe launches a
//   burst of BURST_LEN words (count, count+1, ...) over a valid/ready handshake.
//   Each word must be reported shifted out (spi_done) before the next one is
//   issued, with GAP_CYC idle cycles between words.
//
// Ports
//   clk_100        system clock
//   a_rst_n        asynchronous active-low reset
//   s_rst          synchronous clear, active-high, overrides everything else
//   next_count_pe  1-cycle pulse: increment counter (only honoured while idle)
//   start_send_pe  1-cycle pulse: start a burst (only honoured while idle)
//   tx_ready       SPI core accepts the word on tx_data
//   spi_done       1-cycle pulse: current word has been shifted out
//   tx_valid       tx_data holds a word to transmit
//   tx_data        word to transmit; holds its last value when tx_valid=0
//   count          current counter value
//   busy           sequencer is not idle (registered)
//   err_timeout    sticky: a word was not completed within TIMEOUT cycles
//   burst_cnt      completed bursts, wraps at 16 bits
module spi_burst_sequencer #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int GAP_CYC   = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk_100,
  input  logic              a_rst_n,
  input  logic              s_rst,
  input  logic              next_count_pe,
  input  logic              start_send_pe,
  input  logic              tx_ready,
  input  logic              spi_done,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] count,
  output logic              busy,
  output logic              err_timeout,
  output logic [15:0]       burst_cnt
);

  localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [IW-1:0] IDX_LAST = IW'(BURST_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] base, base_n;
  logic [IW-1:0]     idx, idx_n;
  logic [TW-1:0]     tmo;
  logic [GW-1:0]     gap_cnt;
  logic              cnt_inc, burst_inc, tmo_hit;

  // next-state / control
  always_comb begin
    state_n   = state;
    base_n    = base;
    idx_n     = idx;
    cnt_inc   = 1'b0;
    burst_inc = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        cnt_inc = next_count_pe;
        if (start_send_pe) begin
          // base takes the pre-increment value if both pulses coincide
          base_n  = count;
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (tx_valid && tx_ready) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (spi_done) begin
          if (idx == IDX_LAST) begin
            state_n   = IDLE;
            burst_inc = 1'b1;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = (GAP_CYC == 0) ? SEND : GAP;
          end
        end else if (tmo == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_n = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = SEND;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state       <= IDLE;
      base        <= '0;
      idx         <= '0;
      tmo         <= '0;
      gap_cnt     <= '0;
      count       <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      burst_cnt   <= '0;
    end else if (s_rst) begin
      state       <= IDLE;
      base        <= '0;
      idx         <= '0;
      tmo         <= '0;
      gap_cnt     <= '0;
      count       <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      state <= state_n;
      base  <= base_n;
      idx   <= idx_n;
      if (cnt_inc) count <= count + 1'b1;
      // Both counters run only inside their state, so they read zero on entry.
      tmo     <= (state == WAIT_DONE) ? tmo + 1'b1 : '0;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      // Outputs are registered off the next state so they line up with it.
      tx_valid <= (state_n == SEND);
      busy     <= (state_n != IDLE);
      // Load the word only on entry to SEND so it stays stable under backpressure.
      if (state_n == SEND && state != SEND) tx_data <= base_n + DATA_W'(idx_n);
      if (tmo_hit)   err_timeout <= 1'b1;
      if (burst_inc) burst_cnt   <= burst_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
module tb_spi_burst_sequencer;

  logic       clk_100 = 1'b0;
  logic       a_rst_n, s_rst, next_count_pe, start_send_pe, tx_ready, spi_done;
  logic       tx_valid, busy, err_timeout;
  logic [7:0] tx_data, count;
  logic [15:0] burst_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  spi_burst_sequencer dut (
    .clk_100(clk_100), .a_rst_n(a_rst_n), .s_rst(s_rst),
    .next_count_pe(next_count_pe), .start_send_pe(start_send_pe),
    .tx_ready(tx_ready), .spi_done(spi_done),
    .tx_valid(tx_valid), .tx_data(tx_data), .count(count), .busy(busy),
    .err_timeout(err_timeout), .burst_cnt(burst_cnt)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct {
    logic       nxt, start, rdy, done;
    logic       e_valid;
    logic [7:0] e_data, e_count;
    logic       e_busy;
  } vec_t;

  vec_t tbl[10];

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, tx_valid, 0);
    chk({nm, "_data"}, tx_data, 0);
    chk({nm, "_count"}, count, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err_timeout, 0);
    chk({nm, "_bcnt"}, burst_cnt, 0);
  endtask

  task automatic pulse_next(input int n);
    repeat (n) begin
      next_count_pe = 1'b1;
      step();
      next_count_pe = 1'b0;
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!tx_valid && n < 50) begin
      step();
      n++;
    end
    chk("valid_wait", tx_valid, 1);
  endtask

  // One word: handshake, spi_done dly cycles later, then check the gap.
  task automatic send_word(input logic [7:0] exp, input int dly, input bit last);
    wait_valid();
    chk("word_data", tx_data, exp);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    chk("hs_drop", tx_valid, 0);
    repeat (dly - 1) step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    chk("done_valid", tx_valid, 0);
    if (!last) begin
      step();
      chk("gap2_valid", tx_valid, 0);
      step();
      chk("gap_end_valid", tx_valid, 1);
    end else begin
      chk("end_busy", busy, 0);
    end
  endtask

  task automatic start_pulse();
    start_send_pe = 1'b1;
    step();
    start_send_pe = 1'b0;
  endtask

  initial begin
    // nxt start rdy done | valid data count busy
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 8'h03, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h03, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 8'h03, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 8'h03, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 8'h03, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h03, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 8'h03, 1'b1};

    a_rst_n = 1'b0; s_rst = 1'b0; next_count_pe = 1'b0; start_send_pe = 1'b0;
    tx_ready = 1'b0; spi_done = 1'b0;
    step(); step();
    chk_all_zero("reset");
    @(negedge clk_100);
    a_rst_n = 1'b1;
    step();

    // Burst 1 start via table: counter, latency-1 valid, hold, ignores, gap.
    for (int i = 0; i < 10; i++) begin
      next_count_pe = tbl[i].nxt;
      start_send_pe = tbl[i].start;
      tx_ready      = tbl[i].rdy;
      spi_done      = tbl[i].done;
      step();
      next_count_pe = 1'b0; start_send_pe = 1'b0; tx_ready = 1'b0; spi_done = 1'b0;
      chk($sformatf("vec%0d_valid", i), tx_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_data", i), tx_data, tbl[i].e_data);
      chk($sformatf("vec%0d_count", i), count, tbl[i].e_count);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
    end
    send_word(8'h04, 5, 1'b0);
    send_word(8'h05, 5, 1'b0);
    send_word(8'h06, 5, 1'b1);
    chk("b1_bcnt", burst_cnt, 1);

    // Data wrap across 0xFF, then counter wrap.
    pulse_next(251);
    chk("cnt_fe", count, 8'hFE);
    start_pulse();
    send_word(8'hFE, 3, 1'b0);
    send_word(8'hFF, 3, 1'b0);
    send_word(8'h00, 3, 1'b0);
    send_word(8'h01, 3, 1'b1);
    chk("b2_bcnt", burst_cnt, 2);
    pulse_next(3);
    chk("cnt_01", count, 8'h01);
    pulse_next(255);
    chk("cnt_wrap", count, 8'h00);

    // Backpressure: 20 cycles without tx_ready.
    start_pulse();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_valid", tx_valid, 1);
      chk("bp_data", tx_data, 8'h00);
    end
    send_word(8'h00, 2, 1'b0);
    send_word(8'h01, 2, 1'b0);
    send_word(8'h02, 2, 1'b0);
    send_word(8'h03, 2, 1'b1);
    chk("bp_err", err_timeout, 0);
    chk("b3_bcnt", burst_cnt, 3);

    // Timeout: no spi_done after the handshake.
    begin
      int n = 0;
      start_pulse();
      wait_valid();
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      while (!err_timeout && n < 1100) begin
        chk("tmo_busy_pre", busy, 1);
        step();
        n++;
      end
      chk("tmo_cycles", n, 1024);
    end
    chk("tmo_err", err_timeout, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_bcnt", burst_cnt, 3);
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    chk("stray_done_bcnt", burst_cnt, 3);
    start_pulse();
    send_word(8'h00, 4, 1'b0);
    send_word(8'h01, 4, 1'b0);
    send_word(8'h02, 4, 1'b0);
    send_word(8'h03, 4, 1'b1);
    chk("after_tmo_bcnt", burst_cnt, 4);
    chk("err_sticky", err_timeout, 1);

    // Coincident next/start, then both ignored mid-burst.
    pulse_next(16);
    next_count_pe = 1'b1; start_send_pe = 1'b1;
    step();
    next_count_pe = 1'b0; start_send_pe = 1'b0;
    chk("coin_count", count, 8'h11);
    chk("coin_data", tx_data, 8'h10);
    chk("coin_valid", tx_valid, 1);
    next_count_pe = 1'b1; start_send_pe = 1'b1;
    step();
    next_count_pe = 1'b0; start_send_pe = 1'b0;
    chk("mid_count", count, 8'h11);
    chk("mid_data", tx_data, 8'h10);
    send_word(8'h10, 2, 1'b0);
    send_word(8'h11, 2, 1'b0);
    send_word(8'h12, 2, 1'b0);
    send_word(8'h13, 2, 1'b1);
    chk("coin_bcnt", burst_cnt, 5);
    chk("coin_count_end", count, 8'h11);

    // Async reset mid WAIT_DONE: outputs clear without a clock edge.
    start_pulse();
    wait_valid();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    step();
    #2;
    a_rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    @(negedge clk_100);
    a_rst_n = 1'b1;
    step();

    // Sync reset mid WAIT_DONE after one finished burst.
    pulse_next(2);
    start_pulse();
    send_word(8'h02, 2, 1'b0);
    send_word(8'h03, 2, 1'b0);
    send_word(8'h04, 2, 1'b0);
    send_word(8'h05, 2, 1'b1);
    chk("pre_srst_bcnt", burst_cnt, 1);
    start_pulse();
    wait_valid();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    step();
    s_rst = 1'b1;
    #2;
    chk("srst_sync_busy", busy, 1);
    step();
    s_rst = 1'b0;
    chk_all_zero("srst");
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    step();
    chk_all_zero("post_srst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
